// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two valid/ready requesters
// Round-robin (or fixed-priority) grant, one op per cycle, registered per-port result slots.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_src0,
    input  logic [DATA_W-1:0] req0_src1,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_result,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_src0,
    input  logic [DATA_W-1:0] req1_src1,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_result,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src0,
    output logic [DATA_W-1:0] alu_src1,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rr_ptr
);

    localparam logic RR_ON = (RR_EN != 0);

    logic free0, free1;
    logic elig0, elig1;
    logic grant0, grant1;

    // A slot draining this cycle can be refilled in the same cycle.
    assign free0 = !resp0_valid || resp0_ready;
    assign free1 = !resp1_valid || resp1_ready;
    assign elig0 = req0_valid && free0;
    assign elig1 = req1_valid && free1;

    assign grant0 = elig0 && (!elig1 || !RR_ON || !rr_ptr);
    assign grant1 = elig1 && (!elig0 || (RR_ON && rr_ptr));

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Idle cycles present ADD 0+0 so the ALU never sees X operands.
    always_comb begin
        alu_op   = '0;
        alu_src0 = '0;
        alu_src1 = '0;
        if (grant0) begin
            alu_op   = req0_op;
            alu_src0 = req0_src0;
            alu_src1 = req0_src1;
        end else if (grant1) begin
            alu_op   = req1_op;
            alu_src0 = req1_src0;
            alu_src1 = req1_src1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_valid  <= 1'b0;
            resp0_result <= '0;
        end else if (grant0) begin
            resp0_valid  <= 1'b1;
            resp0_result <= alu_result;
        end else if (resp0_ready) begin
            resp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp1_valid  <= 1'b0;
            resp1_result <= '0;
        end else if (grant1) begin
            resp1_valid  <= 1'b1;
            resp1_result <= alu_result;
        end else if (resp1_ready) begin
            resp1_valid  <= 1'b0;
        end
    end

    // Pointer tracks the last grant even in fixed-priority mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (grant0) begin
            rr_ptr <= 1'b1;
        end else if (grant1) begin
            rr_ptr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed vector bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_src0, req0_src1, req1_src0, req1_src1;
    logic        resp0_ready, resp1_ready;

    logic        req0_ready, req1_ready, resp0_valid, resp1_valid, rr_ptr;
    logic [31:0] resp0_result, resp1_result, alu_src0, alu_src1, alu_result;
    logic [4:0]  alu_op;

    logic        fp_req0_ready, fp_req1_ready, fp_resp0_valid, fp_resp1_valid, fp_rr_ptr;
    logic [31:0] fp_resp0_result, fp_resp1_result, fp_alu_src0, fp_alu_src1, fp_alu_result;
    logic [4:0]  fp_alu_op;

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a & b;
            5'd3:    return a | b;
            5'd4:    return a ^ b;
            default: return 32'h0;
        endcase
    endfunction

    assign alu_result    = alu_f(alu_op, alu_src0, alu_src1);
    assign fp_alu_result = alu_f(fp_alu_op, fp_alu_src0, fp_alu_src1);

    alu_share_arbiter #(.DATA_W(32), .OP_W(5), .RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_src0(req0_src0), .req0_src1(req0_src1),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_src0(req1_src0), .req1_src1(req1_src1),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .alu_op(alu_op), .alu_src0(alu_src0), .alu_src1(alu_src1),
        .alu_result(alu_result), .rr_ptr(rr_ptr)
    );

    alu_share_arbiter #(.DATA_W(32), .OP_W(5), .RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
        .req0_src0(req0_src0), .req0_src1(req0_src1),
        .resp0_valid(fp_resp0_valid), .resp0_ready(resp0_ready), .resp0_result(fp_resp0_result),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
        .req1_src0(req1_src0), .req1_src1(req1_src1),
        .resp1_valid(fp_resp1_valid), .resp1_ready(resp1_ready), .resp1_result(fp_resp1_result),
        .alu_op(fp_alu_op), .alu_src0(fp_alu_src0), .alu_src1(fp_alu_src1),
        .alu_result(fp_alu_result), .rr_ptr(fp_rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  op0;
        logic [31:0] a0, b0;
        logic        v1;
        logic [4:0]  op1;
        logic [31:0] a1, b1;
        logic        r0, r1;
        logic        g0, g1;
        logic [4:0]  aop;
        logic [31:0] as0, as1;
        logic        rv0;
        logic [31:0] rres0;
        logic        rv1;
        logic [31:0] rres1;
        logic        ptr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [4:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic r0, input logic r1);
        req0_valid = v0; req0_op = op0; req0_src0 = a0; req0_src1 = b0;
        req1_valid = v1; req1_op = op1; req1_src0 = a1; req1_src1 = b1;
        resp0_ready = r0; resp1_ready = r1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        rst_n = 1'b0;

        vecs[0]  = '{0, 0, 0, 0,           0, 0, 0, 0,               1, 1, 0, 0, 0,     0,      0,      0, 0,  0, 0,     0};
        vecs[1]  = '{1, 0, 5, 7,           0, 0, 0, 0,               1, 1, 1, 0, 0,     5,      7,      1, 12, 0, 0,     1};
        vecs[2]  = '{1, 1, 10, 3,          1, 4, 32'hF0, 32'h0F,     1, 1, 0, 1, 4,     32'hF0, 32'h0F, 0, 12, 1, 32'hFF, 0};
        vecs[3]  = '{1, 1, 10, 3,          1, 4, 32'hF0, 32'h0F,     1, 1, 1, 0, 1,     10,     3,      1, 7,  0, 32'hFF, 1};
        vecs[4]  = '{1, 1, 10, 3,          1, 4, 32'hF0, 32'h0F,     1, 1, 0, 1, 4,     32'hF0, 32'h0F, 0, 7,  1, 32'hFF, 0};
        vecs[5]  = '{1, 1, 10, 3,          1, 4, 32'hF0, 32'h0F,     1, 1, 1, 0, 1,     10,     3,      1, 7,  0, 32'hFF, 1};
        vecs[6]  = '{1, 0, 1, 2,           1, 2, 32'hC, 32'hA,       1, 1, 0, 1, 2,     32'hC,  32'hA,  0, 7,  1, 8,     0};
        vecs[7]  = '{1, 0, 1, 2,           1, 3, 1, 2,               1, 0, 1, 0, 0,     1,      2,      1, 3,  1, 8,     1};
        vecs[8]  = '{1, 0, 2, 2,           1, 3, 1, 2,               1, 0, 1, 0, 0,     2,      2,      1, 4,  1, 8,     1};
        vecs[9]  = '{1, 0, 3, 3,           1, 3, 1, 2,               1, 0, 1, 0, 0,     3,      3,      1, 6,  1, 8,     1};
        vecs[10] = '{1, 0, 4, 4,           1, 3, 1, 2,               1, 1, 0, 1, 3,     1,      2,      0, 6,  1, 3,     0};
        vecs[11] = '{1, 5'h1F, 9, 9,       0, 0, 0, 0,               1, 1, 1, 0, 5'h1F, 9,      9,      1, 0,  0, 3,     1};
        vecs[12] = '{1, 0, 1, 1,           0, 0, 0, 0,               0, 1, 0, 0, 0,     0,      0,      1, 0,  0, 3,     1};

        // Reset, then one grant whose result is discarded by an async reset pulse.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_alu_op", {27'b0, alu_op}, 0);
        chk("idle_alu_src0", alu_src0, 0);
        chk("idle_alu_src1", alu_src1, 0);
        chk("idle_rv0", {31'b0, resp0_valid}, 0);
        chk("idle_ptr", {31'b0, rr_ptr}, 0);
        @(negedge clk);
        drive(1, 0, 5, 7, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_rv0", {31'b0, resp0_valid}, 1);
        chk("pre_rst_res0", resp0_result, 12);
        chk("pre_rst_ptr", {31'b0, rr_ptr}, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rv0", {31'b0, resp0_valid}, 0);
        chk("async_rst_res0", resp0_result, 0);
        chk("async_rst_ptr", {31'b0, rr_ptr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_rv0", {31'b0, resp0_valid}, 0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0,
                  vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].r0, vecs[i].r1);
            #1;
            chk($sformatf("v%0d_req0_ready", i), {31'b0, req0_ready}, {31'b0, vecs[i].g0});
            chk($sformatf("v%0d_req1_ready", i), {31'b0, req1_ready}, {31'b0, vecs[i].g1});
            chk($sformatf("v%0d_alu_op", i), {27'b0, alu_op}, {27'b0, vecs[i].aop});
            chk($sformatf("v%0d_alu_src0", i), alu_src0, vecs[i].as0);
            chk($sformatf("v%0d_alu_src1", i), alu_src1, vecs[i].as1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_resp0_valid", i), {31'b0, resp0_valid}, {31'b0, vecs[i].rv0});
            chk($sformatf("v%0d_resp0_result", i), resp0_result, vecs[i].rres0);
            chk($sformatf("v%0d_resp1_valid", i), {31'b0, resp1_valid}, {31'b0, vecs[i].rv1});
            chk($sformatf("v%0d_resp1_result", i), resp1_result, vecs[i].rres1);
            chk($sformatf("v%0d_rr_ptr", i), {31'b0, rr_ptr}, {31'b0, vecs[i].ptr});
        end

        // Both ports saturated from reset: fixed priority starves port 1, round-robin alternates.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        rst_n = 1'b0;
        #1;
        chk("fp_rst_rv0", {31'b0, fp_resp0_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 0, 1, 1, 1, 0, 2, 2, 1, 1);
            #1;
            chk($sformatf("fp%0d_req0_ready", k), {31'b0, fp_req0_ready}, 1);
            chk($sformatf("fp%0d_req1_ready", k), {31'b0, fp_req1_ready}, 0);
            chk($sformatf("fp%0d_alu_op", k), {27'b0, fp_alu_op}, 0);
            chk($sformatf("fp%0d_alu_src0", k), fp_alu_src0, 1);
            chk($sformatf("fp%0d_alu_src1", k), fp_alu_src1, 1);
            chk($sformatf("rr%0d_req1_ready", k), {31'b0, req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("fp%0d_resp0_valid", k), {31'b0, fp_resp0_valid}, 1);
            chk($sformatf("fp%0d_resp0_result", k), fp_resp0_result, 2);
            chk($sformatf("fp%0d_resp1_valid", k), {31'b0, fp_resp1_valid}, 0);
            chk($sformatf("fp%0d_resp1_result", k), fp_resp1_result, 0);
            chk($sformatf("fp%0d_rr_ptr", k), {31'b0, fp_rr_ptr}, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
